// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared phase encoding, raster constant sets, delay-line tap type
// Rev 1.0
// ============================================================================
package vga_pkg;

    localparam int CNT_W     = 11;
    localparam int MAX_TOTAL = 2048;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_BACK   = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_FRONT  = 2'd3
    } phase_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 48;
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 33;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BACK   = 88;
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FRONT  = 40;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BACK   = 23;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FRONT  = 1;

    // Request-side flags carried to the output by the lead delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic rq;
        logic ls;
        logic fs;
    } tap_t;

endpackage
`default_nettype wire

// File: rtl/vga_axis_cnt.sv
`default_nettype none
// ============================================================================
// vga_axis_cnt : one raster axis - position counter, phase FSM, wrap strobe
// Rev 1.0
// ============================================================================
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int LEN_SYNC   = 96,
    parameter int LEN_BACK   = 48,
    parameter int LEN_ACTIVE = 640,
    parameter int LEN_FRONT  = 16
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             step,
    output logic [CNT_W-1:0] pos,
    output phase_t           phase,
    output logic             wrap
);

    localparam int TOTAL = LEN_SYNC + LEN_BACK + LEN_ACTIVE + LEN_FRONT;

    generate
        if (LEN_SYNC < 1 || LEN_BACK < 1 || LEN_ACTIVE < 1 || LEN_FRONT < 1) begin : g_bad_len
            $error("vga_axis_cnt: every phase length must be at least 1");
        end
        if (TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_axis_cnt: axis total exceeds 2048");
        end
    endgenerate

    logic [CNT_W-1:0] ph_cnt;
    logic [CNT_W-1:0] ph_cnt_nxt;
    logic [CNT_W-1:0] pos_nxt;
    logic [CNT_W-1:0] ph_len_m1;
    logic             ph_last;
    phase_t           phase_nxt;

    always_ff @(posedge pclk) begin
        if (reset) begin
            pos    <= '0;
            ph_cnt <= '0;
            phase  <= PH_SYNC;
        end else begin
            pos    <= pos_nxt;
            ph_cnt <= ph_cnt_nxt;
            phase  <= phase_nxt;
        end
    end

    always_comb begin
        ph_len_m1  = CNT_W'(LEN_SYNC - 1);
        pos_nxt    = pos;
        ph_cnt_nxt = ph_cnt;
        phase_nxt  = phase;

        case (phase)
            PH_SYNC:   ph_len_m1 = CNT_W'(LEN_SYNC - 1);
            PH_BACK:   ph_len_m1 = CNT_W'(LEN_BACK - 1);
            PH_ACTIVE: ph_len_m1 = CNT_W'(LEN_ACTIVE - 1);
            PH_FRONT:  ph_len_m1 = CNT_W'(LEN_FRONT - 1);
            default:   ph_len_m1 = CNT_W'(LEN_SYNC - 1);
        endcase

        ph_last = (ph_cnt == ph_len_m1);
        wrap    = step && (pos == CNT_W'(TOTAL - 1));

        if (step) begin
            pos_nxt = wrap ? '0 : pos + CNT_W'(1);
            if (ph_last) begin
                ph_cnt_nxt = '0;
                case (phase)
                    PH_SYNC:   phase_nxt = PH_BACK;
                    PH_BACK:   phase_nxt = PH_ACTIVE;
                    PH_ACTIVE: phase_nxt = PH_FRONT;
                    PH_FRONT:  phase_nxt = PH_SYNC;
                    default:   phase_nxt = PH_SYNC;
                endcase
            end else begin
                ph_cnt_nxt = ph_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : VGA raster timing with lead-compensated pixel requests
// Rev 1.0
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BACK   = VGA640_H_BACK,
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FRONT  = VGA640_H_FRONT,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BACK   = VGA640_V_BACK,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FRONT  = VGA640_V_FRONT,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int REQ_LEAD = 1,
    parameter int DW       = 8
) (
    input  logic            pclk,
    input  logic            reset,
    input  logic            en,
    output logic            req,
    output logic [10:0]     req_x,
    output logic [10:0]     req_y,
    input  logic [3*DW-1:0] rgb_in,
    output logic            hsync,
    output logic            vsync,
    output logic            valid,
    output logic [DW-1:0]   vga_r,
    output logic [DW-1:0]   vga_g,
    output logic [DW-1:0]   vga_b,
    output logic            line_start,
    output logic            frame_start,
    output logic [15:0]     frame_cnt
);

    generate
        if (REQ_LEAD < 0 || REQ_LEAD > 4) begin : g_bad_lead
            $error("vga_timing_gen: REQ_LEAD must be in 0..4");
        end
    endgenerate

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    phase_t           h_phase;
    phase_t           v_phase;
    logic             h_wrap;
    logic             frame_wrap;
    logic             en_frame;
    tap_t             tap_in;
    tap_t             tap_out;

    vga_axis_cnt #(
        .LEN_SYNC   (H_SYNC),
        .LEN_BACK   (H_BACK),
        .LEN_ACTIVE (H_ACTIVE),
        .LEN_FRONT  (H_FRONT)
    ) u_h_axis (
        .pclk  (pclk),
        .reset (reset),
        .step  (1'b1),
        .pos   (h),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    // The vertical wrap already implies the horizontal wrap, so it marks the frame end.
    vga_axis_cnt #(
        .LEN_SYNC   (V_SYNC),
        .LEN_BACK   (V_BACK),
        .LEN_ACTIVE (V_ACTIVE),
        .LEN_FRONT  (V_FRONT)
    ) u_v_axis (
        .pclk  (pclk),
        .reset (reset),
        .step  (h_wrap),
        .pos   (v),
        .phase (v_phase),
        .wrap  (frame_wrap)
    );

    always_ff @(posedge pclk) begin
        if (reset) begin
            en_frame  <= 1'b0;
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            en_frame  <= en;
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign req   = en_frame && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    assign req_x = req ? h - CNT_W'(H_SYNC + H_BACK) : '0;
    assign req_y = req ? v - CNT_W'(V_SYNC + V_BACK) : '0;

    always_comb begin
        tap_in    = '0;
        tap_in.hs = (h_phase == PH_SYNC);
        tap_in.vs = (v_phase == PH_SYNC);
        tap_in.rq = req;
        tap_in.ls = (h == '0);
        tap_in.fs = (h == '0) && (v == '0);
    end

    // Delay line aligns sync/valid with colour returned by the fixed-latency source.
    generate
        if (REQ_LEAD == 0) begin : g_passthru
            assign tap_out = tap_in;
        end else begin : g_delay
            tap_t pipe [REQ_LEAD];

            always_ff @(posedge pclk) begin
                if (reset) begin
                    for (int i = 0; i < REQ_LEAD; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= tap_in;
                    for (int i = 1; i < REQ_LEAD; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign tap_out = pipe[REQ_LEAD-1];
        end
    endgenerate

    assign hsync       = tap_out.hs ? HS_POL : ~HS_POL;
    assign vsync       = tap_out.vs ? VS_POL : ~VS_POL;
    assign valid       = tap_out.rq;
    assign line_start  = tap_out.ls;
    assign frame_start = tap_out.fs;

    assign {vga_r, vga_g, vga_b} = valid ? rgb_in : '0;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : randomized check of three lead/polarity variants
// Rev 1.0
// ============================================================================
module tb_vga_timing_gen;

    localparam int HS = 3, HB = 2, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 5, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam int MAXN = 16384;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic [23:0] rgb_in = '0;

    logic        a_req, a_hs, a_vs, a_valid, a_ls, a_fs;
    logic [10:0] a_x, a_y;
    logic [7:0]  a_r, a_g, a_b;
    logic [15:0] a_fc;
    logic        b_req, b_hs, b_vs, b_valid, b_ls, b_fs;
    logic [10:0] b_x, b_y;
    logic [7:0]  b_r, b_g, b_b;
    logic [15:0] b_fc;
    logic        c_req, c_hs, c_vs, c_valid, c_ls, c_fs;
    logic [10:0] c_x, c_y;
    logic [7:0]  c_r, c_g, c_b;
    logic [15:0] c_fc;

    always #5 pclk = ~pclk;

    vga_timing_gen #(.H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
                     .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
                     .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(1), .DW(8)) dut_a (
        .pclk(pclk), .reset(reset), .en(en), .req(a_req), .req_x(a_x), .req_y(a_y),
        .rgb_in(rgb_in), .hsync(a_hs), .vsync(a_vs), .valid(a_valid),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .line_start(a_ls),
        .frame_start(a_fs), .frame_cnt(a_fc));

    vga_timing_gen #(.H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
                     .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
                     .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(4), .DW(8)) dut_b (
        .pclk(pclk), .reset(reset), .en(en), .req(b_req), .req_x(b_x), .req_y(b_y),
        .rgb_in(rgb_in), .hsync(b_hs), .vsync(b_vs), .valid(b_valid),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .line_start(b_ls),
        .frame_start(b_fs), .frame_cnt(b_fc));

    vga_timing_gen #(.H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
                     .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
                     .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(0), .DW(8)) dut_c (
        .pclk(pclk), .reset(reset), .en(en), .req(c_req), .req_x(c_x), .req_y(c_y),
        .rgb_in(rgb_in), .hsync(c_hs), .vsync(c_vs), .valid(c_valid),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b), .line_start(c_ls),
        .frame_start(c_fs), .frame_cnt(c_fc));

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        rq;
        logic [10:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
    } rs_t;

    int  errors = 0;
    int  checks = 0;
    int  n = 0;
    bit  armed = 1'b0;
    bit  en_at [MAXN];
    int  vcnt = 0;
    bit  first_track = 1'b0;
    bit  seen_req, seen_va, seen_vb, seen_vc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // Raster state at cycle m since reset, from the timing rules alone.
    function automatic rs_t model(input int m);
        rs_t r;
        int  h, v, f;
        bit  enf;
        h   = m % HT;
        v   = (m / HT) % VT;
        f   = m / FT;
        enf = (f == 0) ? 1'b0 : en_at[f*FT-1];
        r    = '0;
        r.hs = (h < HS);
        r.vs = (v < VS);
        r.rq = enf && (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        r.x  = r.rq ? 11'(h - HS - HB) : 11'd0;
        r.y  = r.rq ? 11'(v - VS - VB) : 11'd0;
        r.ls = (h == 0);
        r.fs = (h == 0) && (v == 0);
        return r;
    endfunction

    function automatic logic [28:0] exp_out(input int lead, input bit hp, input bit vp);
        rs_t t;
        t = (n < lead) ? rs_t'(0) : model(n - lead);
        return {(t.hs ? hp : !hp), (t.vs ? vp : !vp), t.rq,
                (t.rq ? rgb_in : 24'h0), t.ls, t.fs};
    endfunction

    task automatic check_all();
        rs_t         t;
        logic [38:0] rs_exp;
        t      = model(n);
        rs_exp = {t.rq, t.x, t.y, 16'((n / FT) % 65536)};
        check("a_reqside", {a_req, a_x, a_y, a_fc}, rs_exp);
        check("b_reqside", {b_req, b_x, b_y, b_fc}, rs_exp);
        check("c_reqside", {c_req, c_x, c_y, c_fc}, rs_exp);
        check("a_out", {a_hs, a_vs, a_valid, a_r, a_g, a_b, a_ls, a_fs}, exp_out(1, 1'b1, 1'b1));
        check("b_out", {b_hs, b_vs, b_valid, b_r, b_g, b_b, b_ls, b_fs}, exp_out(4, 1'b0, 1'b0));
        check("c_out", {c_hs, c_vs, c_valid, c_r, c_g, c_b, c_ls, c_fs}, exp_out(0, 1'b1, 1'b1));

        if (n % FT == 0) vcnt = 0;
        if (c_valid) vcnt++;
        if (n % FT == FT - 1)
            check("frame_valid", vcnt,
                  ((n / FT) > 0 && en_at[(n / FT) * FT - 1]) ? HA * VA : 0);

        if (first_track) begin
            if (!seen_req && a_req) begin
                seen_req = 1'b1;
                check("first_req_cycle", n, FT + (VS + VB) * HT + HS + HB);
                check("first_req_xy", {a_x, a_y}, 22'd0);
            end
            if (!seen_va && a_valid) begin
                seen_va = 1'b1;
                check("first_valid_a", n, FT + (VS + VB) * HT + HS + HB + 1);
                check("first_red_a", a_r, rgb_in[23:16]);
            end
            if (!seen_vb && b_valid) begin
                seen_vb = 1'b1;
                check("first_valid_b", n, FT + (VS + VB) * HT + HS + HB + 4);
            end
            if (!seen_vc && c_valid) begin
                seen_vc = 1'b1;
                check("first_valid_c", n, FT + (VS + VB) * HT + HS + HB);
            end
        end
    endtask

    task automatic cycle(input bit rst_v, input bit en_v, input logic [23:0] rgb_v);
        reset  = rst_v;
        en     = en_v;
        rgb_in = rgb_v;
        if (armed && n < MAXN) en_at[n] = en_v;
        @(negedge pclk);
        if (armed) check_all();
        @(posedge pclk);
        if (rst_v) begin
            n     = 0;
            armed = 1'b1;
        end else if (armed) begin
            n++;
        end
        #1;
    endtask

    initial begin
        bit en_v;
        seen_req = 1'b0;
        seen_va  = 1'b0;
        seen_vb  = 1'b0;
        seen_vc  = 1'b0;
        @(posedge pclk);
        #1;
        repeat (3) cycle(1'b1, 1'b1, $urandom);

        first_track = 1'b1;
        repeat (4 * FT) cycle(1'b0, 1'b1, $urandom);
        first_track = 1'b0;
        check("first_req_seen", {seen_req, seen_va, seen_vb, seen_vc}, 4'hF);

        // en drops mid frame 4 and returns mid frame 5
        repeat (3 * FT) cycle(1'b0, !(n >= 4 * FT + 70 && n < 5 * FT + 70), $urandom);

        repeat (2 * FT) cycle(1'b0, 1'b1, 24'hFFFFFF);

        en_v = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(59) == 0) en_v = !en_v;
            cycle(($urandom_range(799) == 0), en_v,
                  ($urandom_range(3) == 0) ? 24'hFFFFFF : 24'($urandom));
        end

        // Reset for one cycle in the middle of an active line
        for (int i = 0; i < 3 * FT && !(n >= 2 * FT && n % HT == HS + HB + 3); i++)
            cycle(1'b0, 1'b1, $urandom);
        cycle(1'b1, 1'b1, $urandom);
        repeat (3 * FT) cycle(1'b0, 1'b1, $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
